fifo_rr_wr_arbiter: RTL and testbench

Shares the write port of the 8-bit synchronous FIFO among NUM_REQ producers.
- Arbitration is round-robin with a bounded burst length per grant.
- The block drives the FIFO's wr/data_in pair and honours fifo_full.
- Sits between producer blocks and fifo_top; one instance per shared FIFO.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_rr_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_rr_wr_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and related schedulers.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning upward from last_grant+1 with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int unsigned cand;

  // Explicit wrap compare keeps non-power-of-two NUM_REQ correct.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_grant_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found_o && req_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with a bounded burst per grant and a bubble cycle between grants.
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_wdata,
  output logic                        grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               granted;
  logic               owner_req;
  logic               accept;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign granted   = (state_q == ST_GRANT);
  assign owner_req = granted & req[owner_q];
  assign accept    = owner_req & ~fifo_full;

  assign grant_vld = granted;
  assign grant_id  = granted ? owner_q : '0;
  assign fifo_wr   = owner_req;
  // Data is gated by the owner's req so an idle producer's bus never leaks X.
  assign fifo_wdata = owner_req ? data_arr[owner_q] : '0;

  always_comb begin
    ack = '0;
    if (accept) ack[owner_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
          end
        end else if (!owner_req) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed bench for fifo_rr_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_fifo_rr_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full = 1'b0;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        grant_vld;
  logic [1:0]  grant_id;

  logic [7:0]  pdata [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0]  got [$];
  int          adv = -1;
  int          errors = 0;
  int          checks = 0;

  assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

  always #5 clk = ~clk;

  fifo_rr_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check 1ns later, log any accepted word.
  task automatic step(input logic r, input logic [3:0] rq, input logic full,
                      input logic [3:0] e_ack, input logic e_gv, input logic [1:0] e_gid);
    @(negedge clk);
    if (adv >= 0) begin
      pdata[adv] = pdata[adv] + 8'h01;
      adv = -1;
    end
    rst       = r;
    req       = rq;
    fifo_full = full;
    #1;
    chk("ack",       32'(ack),       32'(e_ack));
    chk("grant_vld", 32'(grant_vld), 32'(e_gv));
    chk("grant_id",  32'(grant_id),  32'(e_gid));
    chk("fifo_wr",   32'(fifo_wr),   32'(e_gv & rq[e_gid]));
    if (e_gv & rq[e_gid]) chk("fifo_wdata", 32'(fifo_wdata), 32'(pdata[e_gid]));
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) begin
        got.push_back(fifo_wdata);
        adv = i;
      end
    end
  endtask

  logic [7:0] exp_words [38] = '{
    8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6,
    8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
    8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
    8'h04, 8'h05, 8'h06, 8'h07,
    8'h14, 8'h15, 8'h16, 8'h17,
    8'h34, 8'h35, 8'h08,
    8'h24, 8'h25, 8'h18,
    8'h36, 8'h09};

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state
    step(1, 4'b0000, 0, 4'b0000, 0, 2'd0);
    step(1, 4'b0100, 0, 4'b0000, 0, 2'd0);

    // Single producer 2, A1..A6, burst of 4 then bubble and re-grant
    pdata[2] = 8'hA1;
    step(0, 4'b0100, 0, 4'b0000, 0, 2'd0);
    for (int j = 0; j < 4; j++) step(0, 4'b0100, 0, 4'b0100, 1, 2'd2);
    step(0, 4'b0100, 0, 4'b0000, 0, 2'd0);
    for (int j = 0; j < 2; j++) step(0, 4'b0100, 0, 4'b0100, 1, 2'd2);
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd2);
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    // All four requesting: order 0,1,2,3,0 with 4 acks and 1 bubble each
    step(1, 4'b0000, 0, 4'b0000, 0, 2'd0);
    pdata[0] = 8'h00; pdata[1] = 8'h10; pdata[2] = 8'h20; pdata[3] = 8'h30;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b1111, 0, 4'b0000, 0, 2'd0);
      for (int j = 0; j < 4; j++) step(0, 4'b1111, 0, 4'(1 << order[k]), 1, 2'(order[k]));
    end
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    // Producer 1 stalled by fifo_full for 3 cycles mid-burst
    step(0, 4'b0010, 0, 4'b0000, 0, 2'd0);
    for (int j = 0; j < 2; j++) step(0, 4'b0010, 0, 4'b0010, 1, 2'd1);
    for (int j = 0; j < 3; j++) step(0, 4'b0010, 1, 4'b0000, 1, 2'd1);
    for (int j = 0; j < 2; j++) step(0, 4'b0010, 0, 4'b0010, 1, 2'd1);
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    // Producer 3 drops req after 2 words; pending producer 0 follows
    step(0, 4'b1001, 0, 4'b0000, 0, 2'd0);
    for (int j = 0; j < 2; j++) step(0, 4'b1001, 0, 4'b1000, 1, 2'd3);
    step(0, 4'b0001, 0, 4'b0000, 1, 2'd3);
    step(0, 4'b0001, 0, 4'b0000, 0, 2'd0);
    step(0, 4'b0001, 0, 4'b0001, 1, 2'd0);
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd0);
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    // Async reset mid-burst of producer 2, then 1 and 3 pending
    step(0, 4'b0100, 0, 4'b0000, 0, 2'd0);
    for (int j = 0; j < 2; j++) step(0, 4'b0100, 0, 4'b0100, 1, 2'd2);
    step(1, 4'b0100, 0, 4'b0000, 0, 2'd0);
    step(0, 4'b1010, 0, 4'b0000, 0, 2'd0);
    step(0, 4'b1010, 0, 4'b0010, 1, 2'd1);
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd1);
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    // Wrap from last_grant=3 to producer 0
    step(0, 4'b1000, 0, 4'b0000, 0, 2'd0);
    step(0, 4'b1000, 0, 4'b1000, 1, 2'd3);
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd3);
    step(0, 4'b1001, 0, 4'b0000, 0, 2'd0);
    step(0, 4'b1001, 0, 4'b0001, 1, 2'd0);
    step(0, 4'b0000, 0, 4'b0000, 1, 2'd0);
    step(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    // Accepted words in ack order
    chk("word_count", 32'(got.size()), 32'd38);
    for (int i = 0; i < 38; i++) begin
      if (i < got.size()) chk($sformatf("word%0d", i), 32'(got[i]), 32'(exp_words[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
